// File: rtl/conv_coprocessor_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : conv_coprocessor_ctrl
// Purpose  : Instruction-queue controller that sequences register-file and
//            execution-unit work for the convolution coprocessor.
//            Optional execution watchdog: define CONV_CTRL_WATCHDOG_EN.
// Revision : 1.0 - initial release
// ============================================================================
module conv_coprocessor_ctrl #(
    parameter int FIFO_DEPTH  = 4,
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 6,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       instruction,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic [DATA_W-1:0] output_reg,
    output logic              rd_valid,
    output logic              wait_signal,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              exu_start,
    output logic [3:0]        exu_op,
    input  logic              exu_done,
    output logic              exu_abort,
    input  logic              ext_request,
    output logic              ext_grant,
    output logic              err_illegal,
    output logic              err_timeout,
    output logic [15:0]       retire_count
);
    localparam int c_ptr_w = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(FIFO_DEPTH);

    localparam logic [3:0] c_op_nop   = 4'b0000;
    localparam logic [3:0] c_op_read  = 4'b0001;
    localparam logic [3:0] c_op_write = 4'b0010;
    localparam logic [3:0] c_op_conv  = 4'b0101;
    localparam logic [3:0] c_op_trsp  = 4'b0110;
    localparam logic [3:0] c_op_rob   = 4'b0111;
    localparam logic [3:0] c_op_b2g   = 4'b1000;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_GRANT  = 3'd1,
        S_DECODE = 3'd2,
        S_MEM_RD = 3'd3,
        S_MEM_WR = 3'd4,
        S_EXEC   = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [31:0]         mem_q [FIFO_DEPTH];
    logic [31:0]         mem_d [FIFO_DEPTH];
    logic [c_ptr_w-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [c_cnt_w-1:0]  count_q, count_d;
    logic [31:0]         ir_q, ir_d;
    logic                instr_ready_q, instr_ready_d;
    logic [DATA_W-1:0]   output_reg_q, output_reg_d;
    logic                rd_valid_q, rd_valid_d;
    logic                wait_q, wait_d;
    logic                rf_we_q, rf_we_d;
    logic [ADDR_W-1:0]   rf_addr_q, rf_addr_d;
    logic [DATA_W-1:0]   rf_wdata_q, rf_wdata_d;
    logic                exu_start_q, exu_start_d;
    logic [3:0]          exu_op_q, exu_op_d;
    logic                ext_grant_q, ext_grant_d;
    logic                err_illegal_q, err_illegal_d;
    logic [15:0]         retire_q, retire_d;
    logic                w_push, w_pop;

    logic [3:0]          w_op;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_data;
    logic                w_unused_ir;

    assign w_op        = ir_q[3:0];
    assign w_addr      = ir_q[4 +: ADDR_W];
    assign w_data      = ir_q[12 +: DATA_W];
    assign w_unused_ir = ^ir_q;

`ifdef CONV_CTRL_WATCHDOG_EN
    localparam int c_wd_w = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_wd_w-1:0] c_wd_last = c_wd_w'(TIMEOUT_CYC - 1);
    logic [c_wd_w-1:0]   wd_q, wd_d;
    logic                exu_abort_q, exu_abort_d;
    logic                err_timeout_q, err_timeout_d;
`endif

    always_comb begin
        state_d       = state_q;
        mem_d         = mem_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        ir_d          = ir_q;
        output_reg_d  = output_reg_q;
        rd_valid_d    = 1'b0;
        rf_we_d       = 1'b0;
        rf_addr_d     = rf_addr_q;
        rf_wdata_d    = rf_wdata_q;
        exu_start_d   = exu_start_q;
        exu_op_d      = exu_op_q;
        err_illegal_d = err_illegal_q;
        retire_d      = retire_q;
        w_push        = instr_valid && instr_ready_q;
        w_pop         = 1'b0;
`ifdef CONV_CTRL_WATCHDOG_EN
        wd_d          = wd_q;
        exu_abort_d   = 1'b0;
        err_timeout_d = err_timeout_q;
`endif

        case (state_q)
            S_IDLE: begin
                // External agent wins over queued work so it is never starved.
                if (ext_request) begin
                    state_d = S_GRANT;
                end else if (count_q != '0) begin
                    w_pop   = 1'b1;
                    ir_d    = mem_q[rd_ptr_q];
                    state_d = S_DECODE;
                end
            end
            S_GRANT: begin
                if (!ext_request) state_d = S_IDLE;
            end
            S_DECODE: begin
                state_d = S_IDLE;
                case (w_op)
                    c_op_read: begin
                        state_d   = S_MEM_RD;
                        rf_addr_d = w_addr;
                    end
                    c_op_write: begin
                        state_d    = S_MEM_WR;
                        rf_we_d    = 1'b1;
                        rf_addr_d  = w_addr;
                        rf_wdata_d = w_data;
                    end
                    c_op_conv, c_op_trsp, c_op_rob, c_op_b2g: begin
                        state_d     = S_EXEC;
                        exu_start_d = 1'b1;
                        exu_op_d    = w_op;
                        rf_addr_d   = w_addr;
`ifdef CONV_CTRL_WATCHDOG_EN
                        wd_d        = '0;
`endif
                    end
                    c_op_nop: retire_d = retire_q + 16'd1;
                    default:  err_illegal_d = 1'b1;
                endcase
            end
            S_MEM_RD: begin
                output_reg_d = rf_rdata;
                rd_valid_d   = 1'b1;
                retire_d     = retire_q + 16'd1;
                state_d      = S_IDLE;
            end
            S_MEM_WR: begin
                retire_d = retire_q + 16'd1;
                state_d  = S_IDLE;
            end
            S_EXEC: begin
                if (exu_done) begin
                    state_d     = S_IDLE;
                    exu_start_d = 1'b0;
                    exu_op_d    = 4'd0;
                    retire_d    = retire_q + 16'd1;
                end
`ifdef CONV_CTRL_WATCHDOG_EN
                else if (wd_q == c_wd_last) begin
                    state_d       = S_IDLE;
                    exu_start_d   = 1'b0;
                    exu_op_d      = 4'd0;
                    exu_abort_d   = 1'b1;
                    err_timeout_d = 1'b1;
                end else begin
                    wd_d = wd_q + c_wd_w'(1);
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase

        if (w_push) begin
            mem_d[wr_ptr_q] = instruction;
            wr_ptr_d        = wr_ptr_q + c_ptr_w'(1);
        end
        if (w_pop) rd_ptr_d = rd_ptr_q + c_ptr_w'(1);
        if (w_push && !w_pop)      count_d = count_q + c_cnt_w'(1);
        else if (!w_push && w_pop) count_d = count_q - c_cnt_w'(1);

        // Status outputs are registered copies of the next-cycle condition.
        instr_ready_d = (count_d != c_full);
        wait_d        = (count_d != '0) || (state_d != S_IDLE);
        ext_grant_d   = (state_d == S_GRANT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            mem_q         <= '{default: '0};
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            ir_q          <= '0;
            instr_ready_q <= 1'b0;
            output_reg_q  <= '0;
            rd_valid_q    <= 1'b0;
            wait_q        <= 1'b0;
            rf_we_q       <= 1'b0;
            rf_addr_q     <= '0;
            rf_wdata_q    <= '0;
            exu_start_q   <= 1'b0;
            exu_op_q      <= 4'd0;
            ext_grant_q   <= 1'b0;
            err_illegal_q <= 1'b0;
            retire_q      <= 16'd0;
`ifdef CONV_CTRL_WATCHDOG_EN
            wd_q          <= '0;
            exu_abort_q   <= 1'b0;
            err_timeout_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            mem_q         <= mem_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            ir_q          <= ir_d;
            instr_ready_q <= instr_ready_d;
            output_reg_q  <= output_reg_d;
            rd_valid_q    <= rd_valid_d;
            wait_q        <= wait_d;
            rf_we_q       <= rf_we_d;
            rf_addr_q     <= rf_addr_d;
            rf_wdata_q    <= rf_wdata_d;
            exu_start_q   <= exu_start_d;
            exu_op_q      <= exu_op_d;
            ext_grant_q   <= ext_grant_d;
            err_illegal_q <= err_illegal_d;
            retire_q      <= retire_d;
`ifdef CONV_CTRL_WATCHDOG_EN
            wd_q          <= wd_d;
            exu_abort_q   <= exu_abort_d;
            err_timeout_q <= err_timeout_d;
`endif
        end
    end

    assign instr_ready  = instr_ready_q;
    assign output_reg   = output_reg_q;
    assign rd_valid     = rd_valid_q;
    assign wait_signal  = wait_q;
    assign rf_we        = rf_we_q;
    assign rf_addr      = rf_addr_q;
    assign rf_wdata     = rf_wdata_q;
    assign exu_start    = exu_start_q;
    assign exu_op       = exu_op_q;
    assign ext_grant    = ext_grant_q;
    assign err_illegal  = err_illegal_q;
    assign retire_count = retire_q;

`ifdef CONV_CTRL_WATCHDOG_EN
    assign exu_abort   = exu_abort_q;
    assign err_timeout = err_timeout_q;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = (TIMEOUT_CYC != 0);
    assign exu_abort    = 1'b0;
    assign err_timeout  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_conv_coprocessor_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_coprocessor_ctrl
// Purpose  : Scoreboard bench for conv_coprocessor_ctrl with a register-file
//            and execution-unit model. Watchdog cases use CONV_CTRL_WATCHDOG_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_coprocessor_ctrl;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 6;

    localparam logic [3:0] c_op_nop   = 4'b0000;
    localparam logic [3:0] c_op_read  = 4'b0001;
    localparam logic [3:0] c_op_write = 4'b0010;
    localparam logic [3:0] c_op_conv  = 4'b0101;
    localparam logic [3:0] c_op_trsp  = 4'b0110;
    localparam logic [3:0] c_op_rob   = 4'b0111;
    localparam logic [3:0] c_op_b2g   = 4'b1000;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [31:0]       instruction;
    logic              instr_valid;
    logic              instr_ready;
    logic [DATA_W-1:0] output_reg;
    logic              rd_valid;
    logic              wait_signal;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0] rf_wdata;
    logic [DATA_W-1:0] rf_rdata;
    logic              exu_start;
    logic [3:0]        exu_op;
    logic              exu_done;
    logic              exu_abort;
    logic              ext_request;
    logic              ext_grant;
    logic              err_illegal;
    logic              err_timeout;
    logic [15:0]       retire_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    conv_coprocessor_ctrl #(
        .FIFO_DEPTH (4),
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .TIMEOUT_CYC(16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .output_reg  (output_reg),
        .rd_valid    (rd_valid),
        .wait_signal (wait_signal),
        .rf_we       (rf_we),
        .rf_addr     (rf_addr),
        .rf_wdata    (rf_wdata),
        .rf_rdata    (rf_rdata),
        .exu_start   (exu_start),
        .exu_op      (exu_op),
        .exu_done    (exu_done),
        .exu_abort   (exu_abort),
        .ext_request (ext_request),
        .ext_grant   (ext_grant),
        .err_illegal (err_illegal),
        .err_timeout (err_timeout),
        .retire_count(retire_count)
    );

    // Register-file and execution-unit models
    logic [DATA_W-1:0] rf_mem [64];
    assign rf_rdata = rf_mem[rf_addr];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) rf_mem[i] <= '0;
        end else if (rf_we) begin
            rf_mem[rf_addr] <= rf_wdata;
        end
    end

    int   exu_cnt = 0;
    int   exu_lat;
    logic exu_stall;
    always @(posedge clk) exu_cnt <= exu_start ? exu_cnt + 1 : 0;
    assign exu_done = exu_start && !exu_stall && (exu_cnt >= exu_lat - 1);

    // Scoreboard
    typedef struct packed { logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data; } wr_t;
    typedef struct packed { logic [3:0] op; logic [ADDR_W-1:0] addr; } ex_t;
    wr_t               exp_wr [$];
    logic [DATA_W-1:0] exp_rd [$];
    ex_t               exp_ex [$];
    wr_t               mon_wr;
    ex_t               mon_ex;
    logic [DATA_W-1:0] mon_rd;
    logic              prev_start = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (rf_we) begin
                n_tests++;
                if (exp_wr.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_write unexpected: addr=%0d data=0x%0h", rf_addr, rf_wdata);
                end else begin
                    mon_wr = exp_wr.pop_front();
                    if (rf_addr !== mon_wr.addr || rf_wdata !== mon_wr.data) begin
                        n_fail++;
                        $display("FAIL sb_write: got addr=%0d data=0x%0h, want addr=%0d data=0x%0h",
                                 rf_addr, rf_wdata, mon_wr.addr, mon_wr.data);
                    end
                end
            end
            if (rd_valid) begin
                n_tests++;
                if (exp_rd.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_read unexpected: output_reg=0x%0h", output_reg);
                end else begin
                    mon_rd = exp_rd.pop_front();
                    if (output_reg !== mon_rd) begin
                        n_fail++;
                        $display("FAIL sb_read: got 0x%0h, want 0x%0h", output_reg, mon_rd);
                    end
                end
            end
            if (exu_start && !prev_start) begin
                n_tests++;
                if (exp_ex.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_exec unexpected: op=0x%0h addr=%0d", exu_op, rf_addr);
                end else begin
                    mon_ex = exp_ex.pop_front();
                    if (exu_op !== mon_ex.op || rf_addr !== mon_ex.addr) begin
                        n_fail++;
                        $display("FAIL sb_exec: got op=0x%0h addr=%0d, want op=0x%0h addr=%0d",
                                 exu_op, rf_addr, mon_ex.op, mon_ex.addr);
                    end
                end
            end
        end
        prev_start <= rst_n ? exu_start : 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [3:0] op, input logic [7:0] addr,
                                       input logic [15:0] data);
        return {4'hA, data, addr, op};
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge
    // with instr_valid still high so pushes can run back-to-back.
    task automatic push(input logic [31:0] ins);
        int n = 0;
        instruction = ins;
        instr_valid = 1'b1;
        while (!instr_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) check("push_ready_timeout", 32'(instr_ready), 1);
        @(negedge clk);
    endtask

    task automatic wait_start(input string name);
        int n = 0;
        while (!exu_start && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(exu_start), 1);
    endtask

    task automatic wait_retire(input string name, input logic [15:0] target);
        int n = 0;
        while (retire_count != target && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(retire_count), 32'(target));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ready"},   32'(instr_ready), 0);
        check({tag, "_outreg"},  32'(output_reg), 0);
        check({tag, "_rdvalid"}, 32'(rd_valid), 0);
        check({tag, "_wait"},    32'(wait_signal), 0);
        check({tag, "_rfport"},  32'({rf_we, rf_addr, rf_wdata}), 0);
        check({tag, "_exu"},     32'({exu_start, exu_op, exu_abort}), 0);
        check({tag, "_grant"},   32'(ext_grant), 0);
        check({tag, "_errors"},  32'({err_illegal, err_timeout}), 0);
        check({tag, "_retire"},  32'(retire_count), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int   n;
        logic flag;
        instruction = '0;
        instr_valid = 1'b0;
        ext_request = 1'b0;
        exu_stall   = 1'b0;
        exu_lat     = 1;
        rst_n       = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 32'(instr_ready), 1);

        // WRITE addr 5 <- 0x1234: DECODE, then one MEM_WR cycle
        exp_wr.push_back('{addr: 6'd5, data: 16'h1234});
        push(mk(c_op_write, 8'd5, 16'h1234));
        instr_valid = 1'b0;
        @(negedge clk);
        check("wr_decode_no_we", 32'(rf_we), 0);
        check("wr_busy_wait", 32'(wait_signal), 1);
        @(negedge clk);
        check("wr_we_pulse", 32'(rf_we), 1);
        check("wr_addr", 32'(rf_addr), 5);
        check("wr_data", 32'(rf_wdata), 32'h1234);
        @(negedge clk);
        check("wr_we_single", 32'(rf_we), 0);
        check("wr_retire", 32'(retire_count), 1);
        check("wr_idle_wait", 32'(wait_signal), 0);

        // READ addr 5: rd_valid in the cycle after the third edge
        exp_rd.push_back(16'h1234);
        push(mk(c_op_read, 8'd5, 16'h0));
        instr_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rd_not_early", 32'(rd_valid), 0);
        @(negedge clk);
        check("rd_valid_pulse", 32'(rd_valid), 1);
        check("rd_output", 32'(output_reg), 32'h1234);
        @(negedge clk);
        check("rd_valid_single", 32'(rd_valid), 0);
        check("rd_retire", 32'(retire_count), 2);

        // Illegal opcode, then a WRITE and a NOP execute normally
        exp_wr.push_back('{addr: 6'd7, data: 16'hBEEF});
        push(mk(4'b0011, 8'd7, 16'hDEAD));
        push(mk(c_op_write, 8'd7, 16'hBEEF));
        push(mk(c_op_nop, 8'd0, 16'h0));
        instr_valid = 1'b0;
        repeat (12) @(negedge clk);
        check("illegal_flag", 32'(err_illegal), 1);
        check("illegal_not_retired", 32'(retire_count), 4);

        // Fill the queue behind a stalled CONV; the sixth must wait for a pop
        exu_stall = 1'b1;
        exu_lat   = 3;
        exp_ex.push_back('{op: c_op_conv, addr: 6'd1});
        exp_wr.push_back('{addr: 6'd10, data: 16'h0A0A});
        exp_wr.push_back('{addr: 6'd11, data: 16'h0B0B});
        exp_rd.push_back(16'h0A0A);
        exp_ex.push_back('{op: c_op_b2g, addr: 6'd3});
        exp_ex.push_back('{op: c_op_rob, addr: 6'd2});
        push(mk(c_op_conv, 8'd1, 16'h0));
        push(mk(c_op_write, 8'd10, 16'h0A0A));
        push(mk(c_op_write, 8'd11, 16'h0B0B));
        push(mk(c_op_read, 8'd10, 16'h0));
        push(mk(c_op_b2g, 8'd3, 16'h0));
        instruction = mk(c_op_rob, 8'd2, 16'h0);
        instr_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("full_ready_low", 32'(instr_ready), 0);
            @(negedge clk);
        end
        check("stall_wait", 32'(wait_signal), 1);
        check("stall_no_retire", 32'(retire_count), 4);
        exu_stall = 1'b0;
        push(mk(c_op_rob, 8'd2, 16'h0));
        instr_valid = 1'b0;
        wait_retire("burst_retire", 16'd10);

        // CONV taking 10 cycles with an external request raised mid-flight
        exu_lat = 10;
        exp_ex.push_back('{op: c_op_trsp, addr: 6'd4});
        exp_wr.push_back('{addr: 6'd12, data: 16'h0C0C});
        push(mk(c_op_trsp, 8'd4, 16'h0));
        push(mk(c_op_write, 8'd12, 16'h0C0C));
        instr_valid = 1'b0;
        wait_start("trsp_start");
        n    = 0;
        flag = 1'b0;
        while (exu_start && n < 50) begin
            if (n == 2) ext_request = 1'b1;
            if (ext_grant) flag = 1'b1;
            n++;
            @(negedge clk);
        end
        check("trsp_exec_cycles", 32'(n), 10);
        check("grant_deferred", 32'(flag), 0);
        check("trsp_retired", 32'(retire_count), 11);
        @(negedge clk);
        check("grant_asserted", 32'(ext_grant), 1);
        repeat (5) @(negedge clk);
        check("grant_held", 32'(ext_grant), 1);
        check("grant_no_pop", 32'(retire_count), 11);
        check("grant_wait", 32'(wait_signal), 1);
        ext_request = 1'b0;
        wait_retire("post_grant_retire", 16'd12);
        check("grant_released", 32'(ext_grant), 0);

`ifdef CONV_CTRL_WATCHDOG_EN
        // CONV that never completes must be aborted after 16 EXEC cycles
        exu_stall = 1'b1;
        exp_ex.push_back('{op: c_op_conv, addr: 6'd9});
        push(mk(c_op_conv, 8'd9, 16'h0));
        instr_valid = 1'b0;
        wait_start("wd_start");
        n = 0;
        while (!exu_abort && n < 100) begin
            if (exu_start) n++;
            @(negedge clk);
        end
        check("wd_exec_cycles", 32'(n), 16);
        check("wd_abort", 32'(exu_abort), 1);
        check("wd_start_dropped", 32'(exu_start), 0);
        check("wd_err_timeout", 32'(err_timeout), 1);
        check("wd_not_retired", 32'(retire_count), 12);
        @(negedge clk);
        check("wd_abort_single", 32'(exu_abort), 0);
`else
        // Without the watchdog a stalled CONV waits and never aborts
        exu_stall = 1'b1;
        exp_ex.push_back('{op: c_op_conv, addr: 6'd9});
        push(mk(c_op_conv, 8'd9, 16'h0));
        instr_valid = 1'b0;
        wait_start("nowd_start");
        flag = 1'b0;
        repeat (40) begin
            if (exu_abort || err_timeout) flag = 1'b1;
            @(negedge clk);
        end
        check("nowd_no_abort", 32'(flag), 0);
        check("nowd_still_exec", 32'(exu_start), 1);
        exu_stall = 1'b0;
        wait_retire("nowd_retire", 16'd13);
`endif

        // Reset mid-EXEC discards the in-flight op and the queued WRITE
        exu_stall = 1'b1;
        exp_ex.push_back('{op: c_op_conv, addr: 6'd2});
        push(mk(c_op_conv, 8'd2, 16'h0));
        push(mk(c_op_write, 8'd20, 16'h5555));
        instr_valid = 1'b0;
        wait_start("rst_exec_start");
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_state("midexec_reset");
        exu_stall = 1'b0;
        rst_n     = 1'b1;
        repeat (10) @(negedge clk);
        check("post_reset_idle", 32'(wait_signal), 0);
        check("post_reset_retire", 32'(retire_count), 0);
        check("post_reset_ready", 32'(instr_ready), 1);

        check("sb_write_drained", 32'(exp_wr.size()), 0);
        check("sb_read_drained", 32'(exp_rd.size()), 0);
        check("sb_exec_drained", 32'(exp_ex.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
